sort_unload: RTL and testbench

- Companion to the bubble-sort block, at the opposite end of its data path.
- The sorter accepts elements serially and presents a packed, sorted DEPTH-entry vector. sort_unload captures that vector in one cycle and streams it back out one element per cycle over a valid/ready handshake.
- Two capture banks let the next sorted snapshot be loaded while the previous one is still draining.

---
 rtl/sort_unload_pkg.sv | 28 ++
 rtl/sort_unload_bank.sv | 63 ++++++
 rtl/sort_unload.sv | 95 +++++++++
 tb/tb_sort_unload.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sort_unload_pkg.sv
// sort_pkg: shared types and helpers for the sorter data path.
//
// Holds the element width and vector depth used by the sorter and by
// sort_unload, the element and index types derived from them, the per-bank
// occupancy states and a helper that extracts one element from a packed
// sorted vector. The design is sized by editing BITWIDTH and DEPTH here.
package sort_pkg;

  localparam int BITWIDTH = 3;
  localparam int DEPTH    = 8;   // power of two, >= 2

  typedef logic [BITWIDTH-1:0]       elem_t;
  typedef logic [$clog2(DEPTH)-1:0]  idx_t;

  // Occupancy of one capture bank.
  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  // Element i of a packed vector; element 0 sits in the low bits.
  function automatic elem_t get_elem(input logic [DEPTH*BITWIDTH-1:0] vec,
                                     input idx_t i);
    return vec[i*BITWIDTH +: BITWIDTH];
  endfunction

endpackage

// File: rtl/sort_unload_bank.sv
// sort_unload_bank: one capture bank of sort_unload.
//
// Stores a packed sorted vector together with its emit order and tracks
// whether the bank is empty, full, or part-way through being drained.
//
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   load         capture din/order_in this cycle
//   din          packed vector to capture
//   order_in     1 = emit from element DEPTH-1 downwards
//   xfer         an element of this bank is transferred this cycle
//   last         that transfer is the final element of the snapshot
//   idx          emit position within the snapshot
//   elem         element selected by idx and the stored order
//   occupied     bank holds a snapshot not yet fully drained
module sort_unload_bank
  import sort_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [DEPTH*BITWIDTH-1:0]   din,
  input  logic                        order_in,
  input  logic                        xfer,
  input  logic                        last,
  input  logic [$clog2(DEPTH)-1:0]    idx,
  output logic [BITWIDTH-1:0]         elem,
  output logic                        occupied
);

  logic [DEPTH*BITWIDTH-1:0] data;
  logic                      order;
  bank_state_t               state;
  idx_t                      sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data  <= '0;
      order <= 1'b0;
      state <= BANK_EMPTY;
    end else begin
      if (load) begin
        data  <= din;
        order <= order_in;
      end
      unique case (state)
        BANK_EMPTY:    if (load) state <= BANK_FULL;
        BANK_FULL: begin
          if (xfer && last) state <= BANK_EMPTY;
          else if (xfer)    state <= BANK_DRAINING;
        end
        BANK_DRAINING: if (xfer && last) state <= BANK_EMPTY;
        default:       state <= BANK_EMPTY;
      endcase
    end
  end

  // Descending order walks the vector from the top: DEPTH-1-idx.
  assign sel      = order ? (idx_t'(DEPTH-1) - idx) : idx;
  assign elem     = get_elem(data, sel);
  assign occupied = (state != BANK_EMPTY);

endmodule

// File: rtl/sort_unload.sv
// sort_unload: captures a packed sorted vector in one cycle and streams it
// out one element per cycle over a valid/ready handshake. Two banks let the
// next snapshot be captured while the previous one drains, so consecutive
// snapshots stream back to back.
//
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   load         capture request; accepted only when load_ready is high
//   din          packed vector, element 0 (smallest) in the low bits
//   msb_first    captured with load: 1 = emit DEPTH-1 down to 0
//   load_ready   a free bank exists
//   dout         current element (0 when not valid)
//   dout_valid   dout holds a valid element
//   dout_ready   consumer takes dout this cycle
//   dout_last    dout is the final element of its snapshot
//   busy         at least one bank is occupied
module sort_unload
  import sort_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [DEPTH*BITWIDTH-1:0]   din,
  input  logic                        msb_first,
  output logic                        load_ready,
  output logic [BITWIDTH-1:0]         dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic                        dout_last,
  output logic                        busy
);

  logic [1:0] count;
  logic       wr_bank;
  logic       rd_bank;
  idx_t       idx;

  logic       accept;
  logic       xfer;
  logic       last_xfer;
  elem_t      elem [2];
  logic [1:0] occ;

  assign accept    = load && load_ready;
  assign xfer      = dout_valid && dout_ready;
  assign last_xfer = xfer && (idx == idx_t'(DEPTH-1));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    sort_unload_bank u_bank (
      .clk      (clk),
      .reset    (reset),
      .load     (accept && (wr_bank == 1'(b))),
      .din      (din),
      .order_in (msb_first),
      .xfer     (xfer && (rd_bank == 1'(b))),
      .last     (idx == idx_t'(DEPTH-1)),
      .idx      (idx),
      .elem     (elem[b]),
      .occupied (occ[b])
    );
  end

  // A load and a final transfer in the same cycle cancel out in count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= 2'd0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      idx     <= '0;
    end else begin
      unique case ({accept, last_xfer})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (accept) wr_bank <= ~wr_bank;
      if (xfer) begin
        if (last_xfer) begin
          idx     <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          idx <= idx + idx_t'(1);
        end
      end
    end
  end

  // Outputs depend on registered state only, never on dout_ready or load.
  assign load_ready = (count != 2'd2);
  assign dout_valid = (count != 2'd0);
  assign dout       = dout_valid ? elem[rd_bank] : '0;
  assign dout_last  = dout_valid && (idx == idx_t'(DEPTH-1));
  assign busy       = occ[0] || occ[1];

endmodule

// File: tb/tb_sort_unload.sv
// tb_sort_unload: self-checking bench for sort_unload (BITWIDTH 3, DEPTH 8).
//
// Expected outputs come from a table of hand-derived records and from a
// reference model that keeps every accepted snapshot as a queue of elements
// in emission order.
module tb_sort_unload;

  localparam int BW = 3;
  localparam int DP = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           load;
  logic [DP*BW-1:0] din;
  logic           msb_first;
  logic           load_ready;
  logic [BW-1:0]  dout;
  logic           dout_valid;
  logic           dout_ready;
  logic           dout_last;
  logic           busy;

  int checks = 0;
  int fails  = 0;

  // Reference model: pending elements in the order they must appear.
  logic [BW-1:0] q[$];

  typedef struct {
    logic           l;
    logic [DP*BW-1:0] d;
    logic           m;
    logic           r;
    logic           ev;
    logic [BW-1:0]  ed;
    logic           el;
    logic           elr;
  } vec_t;

  vec_t tbl[$];

  sort_unload dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .din        (din),
    .msb_first  (msb_first),
    .load_ready (load_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DP*BW-1:0] pack8(input int a, input int b,
      input int c, input int d, input int e, input int f, input int g,
      input int h);
    return {3'(h), 3'(g), 3'(f), 3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  function automatic int occupancy();
    return (q.size() + DP - 1) / DP;
  endfunction

  task automatic cmp(input string name, input string field, input int got,
                     input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("[TB] FAIL %s.%s: got %0d expected %0d", name, field, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic [DP*BW-1:0] d,
                               input logic m, input logic r);
    load = l; din = d; msb_first = m; dout_ready = r;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ev,
      input logic [BW-1:0] ed, input logic el, input logic elr, input logic eb);
    cmp(name, "dout_valid", int'(dout_valid), int'(ev));
    cmp(name, "dout",       int'(dout),       int'(ed));
    cmp(name, "dout_last",  int'(dout_last),  int'(el));
    cmp(name, "load_ready", int'(load_ready), int'(elr));
    cmp(name, "busy",       int'(busy),       int'(eb));
  endtask

  task automatic checkModel(input string name);
    logic ev;
    logic [BW-1:0] ed;
    ev = (q.size() != 0);
    ed = ev ? q[0] : '0;
    checkOutput(name, ev, ed, ev && (q.size() % DP == 1), occupancy() < 2, ev);
  endtask

  // Clock edge with model update; returns at the following falling edge.
  task automatic advance();
    logic acc, xf;
    acc = load && (occupancy() < 2);
    xf  = (q.size() != 0) && dout_ready;
    @(posedge clk);
    if (xf) void'(q.pop_front());
    if (acc) begin
      for (int k = 0; k < DP; k++) begin
        int e;
        e = msb_first ? DP - 1 - k : k;
        q.push_back(din[e*BW +: BW]);
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input string name, input logic l,
      input logic [DP*BW-1:0] d, input logic m, input logic r);
    applyStimulus(l, d, m, r);
    checkModel(name);
    advance();
  endtask

  task automatic addRow(input logic l, input logic [DP*BW-1:0] d,
      input logic m, input logic r, input logic ev, input int ed,
      input logic el, input logic elr);
    vec_t v;
    v.l = l; v.d = d; v.m = m; v.r = r;
    v.ev = ev; v.ed = 3'(ed); v.el = el; v.elr = elr;
    tbl.push_back(v);
  endtask

  initial begin
    logic [DP*BW-1:0] sorted, snap_a, snap_b;
    int up[8];
    int dn[8];
    up = '{1, 2, 3, 4, 4, 5, 7, 7};
    dn = '{7, 7, 5, 4, 4, 3, 2, 1};
    sorted = pack8(1, 2, 3, 4, 4, 5, 7, 7);
    snap_a = pack8(0, 1, 2, 3, 4, 5, 6, 7);
    snap_b = pack8(7, 6, 5, 4, 3, 2, 1, 0);

    // Ascending then descending emission of the same sorted vector.
    addRow(1'b1, sorted, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    for (int k = 0; k < DP; k++)
      addRow(1'b0, '0, 1'b0, 1'b1, 1'b1, up[k], k == DP - 1, 1'b1);
    addRow(1'b0, '0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    addRow(1'b1, sorted, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    for (int k = 0; k < DP; k++)
      addRow(1'b0, '0, 1'b0, 1'b1, 1'b1, dn[k], k == DP - 1, 1'b1);
    addRow(1'b0, '0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1);

    reset = 1'b1;
    load = 1'b0; din = '0; msb_first = 1'b0; dout_ready = 1'b0;
    #1;
    checkOutput("reset", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].l, tbl[i].d, tbl[i].m, tbl[i].r);
      checkOutput($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].el,
                  tbl[i].elr, tbl[i].ev);
      advance();
    end

    // Two snapshots while stalled, third load refused, then back-to-back.
    step("two_a", 1'b1, snap_a, 1'b0, 1'b0);
    step("two_b", 1'b1, snap_b, 1'b0, 1'b0);
    step("two_full", 1'b1, pack8(5, 5, 5, 5, 5, 5, 5, 5), 1'b0, 1'b0);
    for (int k = 0; k < 2 * DP; k++)
      step($sformatf("two_drain%0d", k), 1'b0, '0, 1'b0, 1'b1);
    step("two_empty", 1'b0, '0, 1'b0, 1'b1);

    // Alternating ready during a drain.
    step("stall_load", 1'b1, snap_a, 1'b1, 1'b1);
    for (int k = 0; k < 2 * DP; k++)
      step($sformatf("stall%0d", k), 1'b0, '0, 1'b0, (k % 2) == 0);
    step("stall_empty", 1'b0, '0, 1'b0, 1'b1);

    // Load on the same cycle as the final transfer of a single snapshot.
    step("fin_load", 1'b1, snap_b, 1'b0, 1'b1);
    for (int k = 0; k < DP - 1; k++)
      step($sformatf("fin%0d", k), 1'b0, '0, 1'b0, 1'b1);
    step("fin_loadc", 1'b1, pack8(6, 1, 2, 3, 4, 5, 6, 0), 1'b0, 1'b1);
    for (int k = 0; k < DP + 1; k++)
      step($sformatf("finc%0d", k), 1'b0, '0, 1'b0, 1'b1);

    // Reset after three elements of a snapshot have left.
    step("rst_load", 1'b1, snap_a, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++)
      step($sformatf("rst_pre%0d", k), 1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    step("rst_reload", 1'b1, snap_b, 1'b0, 1'b1);
    for (int k = 0; k < DP + 1; k++)
      step($sformatf("rst_post%0d", k), 1'b0, '0, 1'b0, 1'b1);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++)
      step($sformatf("rnd%0d", n), $urandom_range(0, 2) == 0,
           (DP*BW)'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
    for (int n = 0; n < 2 * DP + 2; n++)
      step($sformatf("flush%0d", n), 1'b0, '0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
